cla_bist: RTL and testbench
===========================

# cla_bist

Synthesizable built-in self-test controller that drives the operand side of a `WIDTH`-bit carry-lookahead adder (`a`, `b`, `cin`) and checks its result side (`sum`, `cout`). It sweeps every operand combination, compares each result against an internal golden add, and counts mismatches. It sits beside the CLA in the datapath so adder verification runs on silicon or FPGA without a simulator stimulus bench.

## Interface
- `WIDTH`, default 4: adder operand width.
- `SETTLE`, default 1: wait cycles between driving operands and sampling the result. 0 is legal.
- `ERR_W`, default 10: error counter width.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high. One clock domain only.
- `start`, in, 1: begin a sweep. Accepted in IDLE or DONE.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: sweep complete. Held until the next accepted `start` or reset.
- `pass`, out, 1: `done && err_cnt == 0`.
- `a_o`, out, WIDTH: operand a to the CLA.
- `b_o`, out, WIDTH: operand b to the CLA.
- `cin_o`, out, 1: carry-in to the CLA.
- `sum_i`, in, WIDTH: sum from the CLA.
- `cout_i`, in, 1: carry-out from the CLA.
- `err_cnt`, out, ERR_W: mismatch count. Saturates at all-ones.
- `vec_idx`, out, 2*WIDTH+1: current vector index.
- `fail_valid`, out, 1: first-failure record is valid.
- `fail_vec`, out, 2*WIDTH+1: index of the first failing vector.
- `fail_sum`, out, WIDTH: sum captured at the first failure.
- `fail_cout`, out, 1: cout captured at the first failure.

## Operation
- Vector index `v` is 2*WIDTH+1 bits, with `{a, b, cin} = v` (`cin` is the LSB). The sweep runs v = 0 .. 2^(2*WIDTH+1)-1 in ascending order.
- Expected result: `{cout, sum}` = a + b + cin, computed at WIDTH+1 bits. Any bit difference counts as one error for that vector.
- State machine:
  - IDLE: on `start`, go to DRIVE with v = 0.
  - DRIVE: register `a_o`/`b_o`/`cin_o` from v. Go to WAIT if SETTLE > 0, otherwise go to CHECK.
  - WAIT: stay for exactly SETTLE cycles, then go to CHECK.
  - CHECK: compare `sum_i`/`cout_i` with the expected result and update the counters. If v is the last index, go to DONE. Otherwise increment v and go to DRIVE.
  - DONE: on `start`, clear `err_cnt`, `fail_*` and v, then go to DRIVE.
- `start` in DRIVE, WAIT or CHECK is ignored.
- `err_cnt` saturates and never wraps.
- `vec_idx` does not wrap into a second pass. The last index always ends the sweep.
- Operands stay stable from DRIVE through CHECK.
- Reset at any time, including mid-sweep, forces IDLE. Every output is 0: `busy`, `done`, `pass`, `a_o`, `b_o`, `cin_o`, `err_cnt`, `vec_idx`, and all `fail_*`.

## Timing
- `start` sampled high in IDLE or DONE: the next cycle has `busy` = 1, `done` = 0, and operands = vector 0.
- Each vector takes SETTLE+2 cycles. A full sweep takes 2^(2*WIDTH+1)·(SETTLE+2) cycles: 1536 at the defaults, 1024 with SETTLE = 0.
- The CLA result is sampled on the CHECK-state edge. The CLA path must settle within SETTLE+1 cycles of operand registration.
- `err_cnt`, `fail_*` and `vec_idx` update at the end of CHECK.
- `done` and `pass` rise in the same cycle that `busy` falls.

## Configuration
- `CLA_BIST_FAIL_CAPTURE_EN` defined: on the first mismatch of a sweep, latch `fail_vec`, `fail_sum`, `fail_cout` and set `fail_valid`. Later mismatches leave the record unchanged. The record is cleared by reset or by an accepted `start`.
- `CLA_BIST_FAIL_CAPTURE_EN` undefined: the `fail_*` ports remain but are tied to 0, and no capture registers exist.

## Structure
- Shared package `cla_bist_pkg`: state encoding (IDLE, DRIVE, WAIT, CHECK, DONE) and the localparams for vector count and index width as functions of WIDTH.
- One sub-module, `cla_bist_ref`: combinational golden adder returning the WIDTH+1-bit result from a/b/cin. Instantiate it once in the top.
- Top-level: FSM, settle counter, vector counter, error counter, optional capture registers.

## Test plan
- Correct behavioural CLA, defaults, pulse `start` → `done` = 1 and `pass` = 1 exactly 1536 cycles later, `err_cnt` = 0, `fail_valid` = 0.
- CLA `cout` stuck at 0 → `err_cnt` = 256, `pass` = 0. With the macro defined: `fail_vec` = 31 (a = 0, b = 15, cin = 1), `fail_sum` = 0, `fail_cout` = 0.
- CLA `sum[0]` stuck at 1, with ERR_W = 4 → `err_cnt` saturates at 15. With the macro: `fail_vec` = 0, `fail_sum` = 4'b0001.
- `start` re-pulsed at cycle 200 of a sweep → ignored. `done` still rises at cycle 1536 with `vec_idx` unaffected.
- Reset asserted at cycle 100 → next cycle all outputs are 0 and the FSM is in IDLE. A new `start` completes a clean full sweep.
- SETTLE = 0 with a correct CLA → `done` after 1024 cycles and `pass` = 1. `start` in DONE restarts the sweep with `err_cnt` cleared.

Source files
------------

// File: rtl/cla_bist_pkg.sv
// cla_bist_pkg: shared state encoding and sweep sizing helpers for cla_bist
package cla_bist_pkg;
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
    function automatic int idx_w(input int width);
        return 2 * width + 1;
    endfunction
    function automatic longint vec_cnt(input int width);
        return longint'(1) << idx_w(width);
    endfunction
endpackage

// File: rtl/cla_bist_ref.sv
// cla_bist_ref: combinational golden adder producing {cout, sum} of a + b + cin
module cla_bist_ref #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   res
);
    assign res = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/cla_bist.sv
// cla_bist: exhaustive BIST sweep of a carry-lookahead adder; CLA_BIST_FAIL_CAPTURE_EN adds first-failure capture
module cla_bist
    import cla_bist_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [WIDTH-1:0]       a_o,
    output logic [WIDTH-1:0]       b_o,
    output logic                   cin_o,
    input  logic [WIDTH-1:0]       sum_i,
    input  logic                   cout_i,
    output logic [ERR_W-1:0]       err_cnt,
    output logic [2*WIDTH:0]       vec_idx,
    output logic                   fail_valid,
    output logic [2*WIDTH:0]       fail_vec,
    output logic [WIDTH-1:0]       fail_sum,
    output logic                   fail_cout
);
    localparam int IW = idx_w(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(vec_cnt(WIDTH) - 1);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SLAST = SW'(SETTLE > 0 ? SETTLE - 1 : 0);

    state_t state, state_n;
    logic [SW-1:0] scnt;
    logic [IW-1:0] op;
    logic [WIDTH:0] exp_r;
    logic go, last, mism;

    assign go = start && (state == IDLE || state == DONE);
    assign last = vec_idx == LAST;
    assign mism = state == CHECK && {cout_i, sum_i} != exp_r;
    assign {a_o, b_o, cin_o} = op;
    assign busy = state == DRIVE || state == WAIT || state == CHECK;
    assign done = state == DONE;
    assign pass = done && err_cnt == '0;

    cla_bist_ref #(.WIDTH(WIDTH)) u_ref (
        .a   (a_o),
        .b   (b_o),
        .cin (cin_o),
        .res (exp_r)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // next-state: one DRIVE, SETTLE WAIT cycles, one CHECK per vector
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = start ? DRIVE : state;
            DRIVE: state_n = SETTLE > 0 ? WAIT : CHECK;
            WAIT: state_n = scnt == SLAST ? CHECK : WAIT;
            CHECK: state_n = last ? DONE : DRIVE;
            default: state_n = IDLE;
        endcase
    end

    // operand, vector, settle and saturating error counters
    always_ff @(posedge clk) begin
        if (rst) begin
            op <= '0;
            vec_idx <= '0;
            err_cnt <= '0;
            scnt <= '0;
        end else begin
            if (go) begin
                op <= '0;
                vec_idx <= '0;
                err_cnt <= '0;
            end
            if (state == DRIVE) scnt <= '0;
            if (state == WAIT) scnt <= scnt + 1'b1;
            if (state == CHECK) begin
                if (mism && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
                if (!last) begin
                    vec_idx <= vec_idx + 1'b1;
                    op <= vec_idx + 1'b1;
                end
            end
        end
    end

`ifdef CLA_BIST_FAIL_CAPTURE_EN
    // latch the first mismatch of a sweep; later mismatches leave it alone
    always_ff @(posedge clk) begin
        if (rst || go) begin
            fail_valid <= 1'b0;
            fail_vec <= '0;
            fail_sum <= '0;
            fail_cout <= 1'b0;
        end else if (mism && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec <= vec_idx;
            fail_sum <= sum_i;
            fail_cout <= cout_i;
        end
    end
`else
    assign fail_valid = 1'b0;
    assign fail_vec = '0;
    assign fail_sum = '0;
    assign fail_cout = 1'b0;
`endif
endmodule

// File: tb/tb_cla_bist.sv
// tb_cla_bist: directed table-driven checks of cla_bist against faulty and correct adder models
module tb_cla_bist;
    localparam int NV = 512;
`ifdef CLA_BIST_FAIL_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    typedef struct {
        int fault;
        int err;
        int pass;
        int fvalid;
        int fvec;
        int fsum;
        int fcout;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] st = '0;
    int fm [3] = '{0, 0, 0};
    int checks = 0;
    int failures = 0;
    row_t rows [4];

    logic busy0, done0, pass0, cin0, co0, fv0, fc0;
    logic [3:0] a0, b0, s0, fs0;
    logic [9:0] err0;
    logic [8:0] idx0, fvec0;
    logic busy1, done1, pass1, cin1, co1, fv1, fc1;
    logic [3:0] a1, b1, s1, fs1, err1;
    logic [8:0] idx1, fvec1;
    logic busy2, done2, pass2, cin2, co2, fv2, fc2;
    logic [3:0] a2, b2, s2, fs2;
    logic [9:0] err2;
    logic [8:0] idx2, fvec2;

    always #5 clk = ~clk;

    // adder model: 0 correct, 1 cout stuck 0, 2 cout stuck 1, 3 sum[0] stuck 1
    function automatic logic [4:0] cla(input int f, input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] r;
        r = {1'b0, a} + {1'b0, b} + {4'b0, c};
        if (f == 1) r[4] = 1'b0;
        else if (f == 2) r[4] = 1'b1;
        else if (f == 3) r[0] = 1'b1;
        return r;
    endfunction

    always_comb {co0, s0} = cla(fm[0], a0, b0, cin0);
    always_comb {co1, s1} = cla(fm[1], a1, b1, cin1);
    always_comb {co2, s2} = cla(fm[2], a2, b2, cin2);

    cla_bist u0 (
        .clk(clk), .rst(rst), .start(st[0]), .busy(busy0), .done(done0), .pass(pass0),
        .a_o(a0), .b_o(b0), .cin_o(cin0), .sum_i(s0), .cout_i(co0), .err_cnt(err0),
        .vec_idx(idx0), .fail_valid(fv0), .fail_vec(fvec0), .fail_sum(fs0), .fail_cout(fc0)
    );
    cla_bist #(.ERR_W(4)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .busy(busy1), .done(done1), .pass(pass1),
        .a_o(a1), .b_o(b1), .cin_o(cin1), .sum_i(s1), .cout_i(co1), .err_cnt(err1),
        .vec_idx(idx1), .fail_valid(fv1), .fail_vec(fvec1), .fail_sum(fs1), .fail_cout(fc1)
    );
    cla_bist #(.SETTLE(0)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .busy(busy2), .done(done2), .pass(pass2),
        .a_o(a2), .b_o(b2), .cin_o(cin2), .sum_i(s2), .cout_i(co2), .err_cnt(err2),
        .vec_idx(idx2), .fail_valid(fv2), .fail_vec(fvec2), .fail_sum(fs2), .fail_cout(fc2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // start is sampled on the posedge between the two negedges; returns half a cycle after it
    task automatic pulse(input int i);
        @(negedge clk);
        st[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b0;
    endtask

    task automatic run0(input row_t r, input int n);
        fm[0] = r.fault;
        pulse(0);
        chk($sformatf("r%0d_busy_start", n), busy0, 1);
        chk($sformatf("r%0d_done_start", n), done0, 0);
        chk($sformatf("r%0d_ops_start", n), {a0, b0, cin0}, 0);
        chk($sformatf("r%0d_err_clear", n), err0, 0);
        chk($sformatf("r%0d_fv_clear", n), fv0, 0);
        repeat (NV * 3 - 1) @(negedge clk);
        chk($sformatf("r%0d_done_early", n), done0, 0);
        @(negedge clk);
        chk($sformatf("r%0d_done", n), done0, 1);
        chk($sformatf("r%0d_busy", n), busy0, 0);
        chk($sformatf("r%0d_pass", n), pass0, r.pass);
        chk($sformatf("r%0d_err", n), err0, r.err);
        chk($sformatf("r%0d_idx", n), idx0, NV - 1);
        chk($sformatf("r%0d_fvalid", n), fv0, CAP ? r.fvalid : 0);
        chk($sformatf("r%0d_fvec", n), fvec0, CAP ? r.fvec : 0);
        chk($sformatf("r%0d_fsum", n), fs0, CAP ? r.fsum : 0);
        chk($sformatf("r%0d_fcout", n), fc0, CAP ? r.fcout : 0);
    endtask

    initial begin
        rows[0] = '{1, 256, 0, 1, 31, 0, 0};
        rows[1] = '{0, 0, 1, 0, 0, 0, 0};
        rows[2] = '{2, 256, 0, 1, 0, 0, 1};
        rows[3] = '{0, 0, 1, 0, 0, 0, 0};
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy0, done0, pass0, a0, b0, cin0, err0, idx0, fv0, fvec0, fs0, fc0}, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) run0(rows[i], i);

        // start re-pulsed mid-sweep must be ignored
        fm[0] = 0;
        pulse(0);
        repeat (199) @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        chk("restart_busy", busy0, 1);
        repeat (1335) @(negedge clk);
        chk("restart_done_early", done0, 0);
        @(negedge clk);
        chk("restart_done", done0, 1);
        chk("restart_idx", idx0, NV - 1);
        chk("restart_pass", pass0, 1);

        // reset mid-sweep after a faulty run, then a clean sweep
        fm[0] = 1;
        pulse(0);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_outputs", {busy0, done0, pass0, a0, b0, cin0, err0, idx0, fv0, fvec0, fs0, fc0}, 0);
        repeat (3) @(negedge clk);
        chk("midrst_idle", {busy0, done0, idx0}, 0);
        run0(rows[1], 4);

        // saturating counter with a narrow ERR_W
        fm[1] = 3;
        pulse(1);
        repeat (NV * 3) @(negedge clk);
        chk("sat_done", done1, 1);
        chk("sat_err", err1, 15);
        chk("sat_pass", pass1, 0);
        chk("sat_fvalid", fv1, CAP ? 1 : 0);
        chk("sat_fvec", fvec1, 0);
        chk("sat_fsum", fs1, CAP ? 1 : 0);
        chk("sat_fcout", fc1, 0);

        // SETTLE = 0: faulty sweep, then restart from DONE with a fixed adder
        fm[2] = 1;
        pulse(2);
        repeat (NV * 2 - 1) @(negedge clk);
        chk("s0_done_early", done2, 0);
        @(negedge clk);
        chk("s0_done", done2, 1);
        chk("s0_err", err2, 256);
        fm[2] = 0;
        pulse(2);
        chk("s0_restart_err", err2, 0);
        chk("s0_restart_state", {busy2, done2}, 2'b10);
        repeat (NV * 2 - 1) @(negedge clk);
        chk("s0b_done_early", done2, 0);
        @(negedge clk);
        chk("s0b_done", done2, 1);
        chk("s0b_pass", pass2, 1);
        chk("s0b_idx", idx2, NV - 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
